bcd_serial_adder: RTL

Digit-serial, parametrised multi-digit BCD adder/subtractor. It takes two packed BCD operands of DIGITS digits, then processes one digit per clock, least-significant digit first. It presents the result through a valid/ready output handshake. It sits between BCD operand sources (counters, keypad/display paths) and BCD consumers, and replaces single-digit combinational adders where wide operands would create long carry chains.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_step.sv | 31 +++
 rtl/bcd_serial_adder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit validity helper.
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam int RADIX = 10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic digit_bad(input logic [BCD_W-1:0] d);
      return d > BCD_W'(RADIX - 1);
   endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of add or nine's-complement subtract; purely combinational.
// Flags either operand digit outside 0..9.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_dig,
   input  logic [BCD_W-1:0] b_dig,
   input  logic             sub,
   input  logic             carry_in,
   output logic [BCD_W-1:0] res_dig,
   output logic             carry_out,
   output logic             invalid
);
   logic [BCD_W:0] b_adj;
   logic [BCD_W:0] t;
   logic [BCD_W:0] t_wrap;

   always_comb begin
      b_adj     = sub ? ((BCD_W+1)'(RADIX - 1) - {1'b0, b_dig}) : {1'b0, b_dig};
      t         = {1'b0, a_dig} + b_adj + {{BCD_W{1'b0}}, carry_in};
      t_wrap    = t - (BCD_W+1)'(RADIX);
      res_dig   = t[BCD_W-1:0];
      carry_out = 1'b0;
      if (t >= (BCD_W+1)'(RADIX)) begin
         res_dig   = t_wrap[BCD_W-1:0];
         carry_out = 1'b1;
      end
   end

   assign invalid = digit_bad(a_dig) | digit_bad(b_dig);
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor, LSD first; result valid DIGITS edges after accept.
// Result is held in DONE until out_ready_i; operands are accepted only in IDLE.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [BCD_W*DIGITS-1:0] a_i,
   input  logic [BCD_W*DIGITS-1:0] b_i,
   input  logic                  sub_i,
   input  logic                  carry_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [BCD_W*DIGITS-1:0] sum_o,
   output logic                  carry_o,
   output logic                  error_o
);
   localparam int W  = BCD_W * DIGITS;
   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

   state_t           state, state_nxt;
   logic [KW-1:0]    k;
   logic [W-1:0]     a_q, b_q, res_q, res_nxt;
   logic             sub_q, c_q, err_q;
   logic [BCD_W-1:0] a_dig, b_dig, step_dig;
   logic             step_c, step_bad;
   logic             accept, last;

   assign accept = in_valid_i & in_ready_o;
   assign last   = (k == K_LAST);

   // Per-digit select of the working operands and merge of the new result digit.
   always_comb begin
      a_dig   = '0;
      b_dig   = '0;
      res_nxt = res_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (k == KW'(i)) begin
            a_dig = a_q[i*BCD_W +: BCD_W];
            b_dig = b_q[i*BCD_W +: BCD_W];
            res_nxt[i*BCD_W +: BCD_W] = step_dig;
         end
      end
   end

   bcd_digit_step u_step (
      .a_dig     (a_dig),
      .b_dig     (b_dig),
      .sub       (sub_q),
      .carry_in  (c_q),
      .res_dig   (step_dig),
      .carry_out (step_c),
      .invalid   (step_bad)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid_i) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (out_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state == IDLE);
      out_valid_o = (state == DONE);
   end

   // Invalid digits are accumulated as each position is visited, so by the
   // DONE-entry edge the flag covers every digit of both operands.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sub_q   <= 1'b0;
         c_q     <= 1'b0;
         err_q   <= 1'b0;
         sum_o   <= '0;
         carry_o <= 1'b0;
         error_o <= 1'b0;
      end else if (accept) begin
         a_q   <= a_i;
         b_q   <= b_i;
         sub_q <= sub_i;
         c_q   <= sub_i ? ~carry_i : carry_i;
         err_q <= 1'b0;
         res_q <= '0;
         k     <= '0;
      end else if (state == RUN) begin
         res_q <= res_nxt;
         c_q   <= step_c;
         err_q <= err_q | step_bad;
         k     <= last ? '0 : k + KW'(1);
         if (last) begin
            if (err_q | step_bad) begin
               sum_o   <= '0;
               carry_o <= 1'b0;
               error_o <= 1'b1;
            end else begin
               sum_o   <= res_nxt;
               carry_o <= sub_q ? ~step_c : step_c;
               error_o <= 1'b0;
            end
         end
      end
   end
endmodule
